// File: rtl/tlb_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tlb_cmd_ctrl
//  Brief    : CP0-side initiator for the TLB maintenance port. Accepts
//             TLBR/TLBWI/TLBWR/TLBP from MEM, stalls the pipeline, issues a
//             one-cycle request to the TLB, waits for completion (bounded by a
//             timeout) and writes results back to CP0. Also owns the CP0
//             Random register and its Wired-bounded decrement.
//  Revision : 1.0 - initial release
// ============================================================================

// TLB maintenance request encoding shared with the TLB and the testbench.
typedef enum logic [2:0] {
  NO_REQ = 3'd0,
  TLBR   = 3'd1,
  TLBWI  = 3'd2,
  TLBWR  = 3'd3,
  TLBP   = 3'd4
} tlb_req_t;

// Entry image exchanged with the TLB (request payload and result).
typedef struct packed {
  logic [31:0] index;
  logic [31:0] entryhi;
  logic [31:0] entrylo0;
  logic [31:0] entrylo1;
  logic [31:0] pagemask;
} tlb_t;

module tlb_cmd_ctrl #(
  parameter int TLB_ENTRIES = 32,
  parameter int TIMEOUT     = 15
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           inst_valid,
  input  tlb_req_t                       inst_op,
  input  logic                           flush,
  input  logic [31:0]                    cp0_index,
  input  logic [31:0]                    cp0_entryhi,
  input  logic [31:0]                    cp0_entrylo0,
  input  logic [31:0]                    cp0_entrylo1,
  input  logic [31:0]                    cp0_pagemask,
  input  logic                           wired_we,
  input  logic [$clog2(TLB_ENTRIES)-1:0] wired_wdata,
  output tlb_req_t                       tlb_req,
  output tlb_t                           tlb_info,
  input  logic                           tlb_ok,
  input  tlb_t                           tlb_res,
  output logic                           stall,
  output logic                           done,
  output logic                           err,
  output logic                           wb_index_we,
  output logic [31:0]                    wb_index,
  output logic                           wb_entry_we,
  output logic [31:0]                    wb_entryhi,
  output logic [31:0]                    wb_entrylo0,
  output logic [31:0]                    wb_entrylo1,
  output logic [31:0]                    wb_pagemask,
  output logic [$clog2(TLB_ENTRIES)-1:0] random
);

  localparam int IDX_W = $clog2(TLB_ENTRIES);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0] RAND_MAX  = IDX_W'(TLB_ENTRIES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  tlb_req_t         op_q;
  tlb_req_t         tlb_req_q;
  tlb_t             tlb_info_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q, err_q;
  logic             wb_index_we_q, wb_entry_we_q;
  logic [31:0]      wb_index_q, wb_entryhi_q, wb_entrylo0_q, wb_entrylo1_q, wb_pagemask_q;
  logic [IDX_W-1:0] random_q, wired_q;

  logic             w_accept;
  logic             w_timeout;
  tlb_t             w_info;
  logic             w_unused;

  // Only the low index bits select an entry; the rest of CP0 Index is ignored.
  assign w_unused  = ^cp0_index[31:IDX_W];

  assign w_accept  = (state_q == S_IDLE) && inst_valid && (inst_op != NO_REQ) && !flush;
  // Last permitted WAIT cycle with no answer from the TLB.
  assign w_timeout = (state_q == S_WAIT) && !tlb_ok && (cnt_q == CNT_LAST);

  // Request payload snapshot: TLBWR targets the current Random, others CP0 Index.
  always_comb begin
    w_info          = '0;
    w_info.index    = (inst_op == TLBWR) ? {{(32-IDX_W){1'b0}}, random_q}
                                         : {{(32-IDX_W){1'b0}}, cp0_index[IDX_W-1:0]};
    w_info.entryhi  = cp0_entryhi;
    w_info.entrylo0 = cp0_entrylo0;
    w_info.entrylo1 = cp0_entrylo1;
    w_info.pagemask = cp0_pagemask;
  end

  // FSM state register; reset aborts any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_accept)            state_d = S_ISSUE;
      S_ISSUE:                          state_d = S_WAIT;
      S_WAIT:  if (tlb_ok || w_timeout) state_d = S_DONE;
      S_DONE:                           state_d = S_IDLE;
      default:                          state_d = S_IDLE;
    endcase
  end

  // FSM output: stall covers the accept cycle and the whole TLB round trip.
  always_comb begin
    stall = w_accept || (state_q == S_ISSUE) || (state_q == S_WAIT);
  end

  // Request launch, timeout counting, result capture and completion pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q          <= NO_REQ;
      tlb_req_q     <= NO_REQ;
      tlb_info_q    <= '0;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      wb_index_we_q <= 1'b0;
      wb_entry_we_q <= 1'b0;
      wb_index_q    <= '0;
      wb_entryhi_q  <= '0;
      wb_entrylo0_q <= '0;
      wb_entrylo1_q <= '0;
      wb_pagemask_q <= '0;
    end else begin
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      wb_index_we_q <= 1'b0;
      wb_entry_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            op_q       <= inst_op;
            tlb_req_q  <= inst_op;
            tlb_info_q <= w_info;
            cnt_q      <= '0;
          end
        end
        S_ISSUE: begin
          // One-cycle request so the TLB acts exactly once.
          tlb_req_q <= NO_REQ;
        end
        S_WAIT: begin
          if (tlb_ok) begin
            done_q <= 1'b1;
            cnt_q  <= '0;
            if (op_q == TLBP) begin
              wb_index_we_q <= 1'b1;
              wb_index_q    <= tlb_res.index;
            end
            if (op_q == TLBR) begin
              wb_entry_we_q <= 1'b1;
              wb_entryhi_q  <= tlb_res.entryhi;
              wb_entrylo0_q <= tlb_res.entrylo0;
              wb_entrylo1_q <= tlb_res.entrylo1;
              wb_pagemask_q <= tlb_res.pagemask;
            end
          end else if (w_timeout) begin
            // Abandon without touching CP0.
            done_q <= 1'b1;
            err_q  <= 1'b1;
            cnt_q  <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Random: free-running decrement, reloaded at or below Wired and on Wired writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wired_q  <= '0;
      random_q <= RAND_MAX;
    end else if (wired_we) begin
      wired_q  <= wired_wdata;
      random_q <= RAND_MAX;
    end else if (random_q <= wired_q) begin
      random_q <= RAND_MAX;
    end else begin
      random_q <= random_q - IDX_ONE;
    end
  end

  assign tlb_req     = tlb_req_q;
  assign tlb_info    = tlb_info_q;
  assign done        = done_q;
  assign err         = err_q;
  assign wb_index_we = wb_index_we_q;
  assign wb_index    = wb_index_q;
  assign wb_entry_we = wb_entry_we_q;
  assign wb_entryhi  = wb_entryhi_q;
  assign wb_entrylo0 = wb_entrylo0_q;
  assign wb_entrylo1 = wb_entrylo1_q;
  assign wb_pagemask = wb_pagemask_q;
  assign random      = random_q;

endmodule
`default_nettype wire
